// File: rtl/aes_encrypt.sv
// aes_encrypt: iterative AES-128 encryptor, one full round per clock with on-the-fly key expansion.
// Ports: clk (rising-edge clock), rst (synchronous, active-high), start (accepted only while idle),
//        in (128-bit plaintext, byte 0 in [127:120]), Key (128-bit cipher key, same order),
//        busy (encryption in progress), out (registered ciphertext, held until next completion),
//        done (one-cycle pulse, out valid on the same cycle).
package aes_encrypt_pkg;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
endpackage

// KeySchedule: derives the next AES-128 round key from the current one.
// Ports: Kin (current round key), RC (round constant), Kout (next round key).
module KeySchedule
    import aes_encrypt_pkg::*;
(
    input  logic [127:0] Kin,
    input  logic [7:0]   RC,
    output logic [127:0] Kout
);
    logic [31:0] t, k0, k1, k2, k3;
    // RotWord then SubWord on the last word, round constant folded into the top byte
    assign t  = {SBOX[Kin[23:16]] ^ RC, SBOX[Kin[15:8]], SBOX[Kin[7:0]], SBOX[Kin[31:24]]};
    assign k0 = Kin[127:96] ^ t;
    assign k1 = Kin[95:64] ^ k0;
    assign k2 = Kin[63:32] ^ k1;
    assign k3 = Kin[31:0] ^ k2;
    assign Kout = {k0, k1, k2, k3};
endmodule

module aes_encrypt
    import aes_encrypt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] Key,
    output logic         busy,
    output logic [127:0] out,
    output logic         done
);
    typedef enum logic {IDLE, RUN} fsm_t;
    // indexed by the round counter; entry 0 and 11..15 are never used
    localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fsm_t fsm, fsm_nxt;
    logic [3:0] round;
    logic [127:0] state, rk, nk, sr, mc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    KeySchedule u_ks (.Kin(rk), .RC(RCON[round]), .Kout(nk));

    // SubBytes + ShiftRows: output byte (row r, col c) takes input byte (row r, col (c+r) mod 4)
    for (genvar i = 0; i < 16; i = i + 1) begin : g_sr
        assign sr[127-8*i -: 8] = SBOX[state[127-8*(i%4 + 4*((i/4 + i%4)%4)) -: 8]];
    end

    for (genvar c = 0; c < 4; c = c + 1) begin : g_mc
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign busy = fsm == RUN;

    always_comb begin
        fsm_nxt = fsm;
        fsm_nxt = fsm == IDLE ? (start ? RUN : IDLE) : (round == 4'd10 ? IDLE : RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else fsm <= fsm_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            rk    <= '0;
            round <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fsm == IDLE) begin
                if (start) begin
                    state <= in ^ Key;
                    rk    <= Key;
                    round <= 4'd1;
                end
            end else if (round == 4'd10) begin
                out   <= sr ^ nk;
                done  <= 1'b1;
                round <= '0;
            end else begin
                state <= mc ^ nk;
                rk    <= nk;
                round <= round + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_encrypt.sv
// tb_aes_encrypt: scoreboard bench for aes_encrypt with FIPS-197 vectors and a software AES model.
module tb_aes_encrypt;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RKB = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst, start;
    logic [127:0] pt, key;
    logic busy, done;
    logic [127:0] out;
    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [7:0] sb[256];
    logic [7:0] isb[256];

    aes_encrypt dut (.clk(clk), .rst(rst), .start(start), .in(pt), .Key(key),
                     .busy(busy), .out(out), .done(done));

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse and the affine map, independent of any table
    task automatic build_sbox();
        logic [7:0] inv, s, t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            t = inv;
            for (int j = 0; j < 4; j++) begin
                t = {t[6:0], t[7]};
                s ^= t;
            end
            s ^= 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0] rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int i = 0; i < r; i++) begin
            t = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
            w0 ^= t;
            w1 ^= w0;
            w2 ^= w1;
            w3 ^= w2;
            rc = gmul(rc, 8'h02);
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [127:0] v, kk;
        v = p;
        kk = k;
        for (int i = 0; i < 16; i++) begin
            s[i] = v[127:120] ^ kk[127:120];
            v = v << 8;
            kk = kk << 8;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*c] = sb[s[row + 4*((c + row) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            kk = rkey(k, r);
            for (int i = 0; i < 16; i++) begin
                s[i] ^= kk[127:120];
                kk = kk << 8;
            end
        end
        for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
        return v;
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [127:0] v, kk;
        v = ct;
        kk = rkey(k, 10);
        for (int i = 0; i < 16; i++) begin
            s[i] = v[127:120] ^ kk[127:120];
            v = v << 8;
            kk = kk << 8;
        end
        for (int r = 9; r >= 0; r--) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*((c + row) % 4)] = isb[s[row + 4*c]];
            kk = rkey(k, r);
            for (int i = 0; i < 16; i++) begin
                t[i] ^= kk[127:120];
                kk = kk << 8;
            end
            for (int c = 0; c < 4; c++) begin
                if (r > 0) begin
                    s[4*c]   = gmul(t[4*c], 14) ^ gmul(t[4*c+1], 11) ^ gmul(t[4*c+2], 13) ^ gmul(t[4*c+3], 9);
                    s[4*c+1] = gmul(t[4*c], 9) ^ gmul(t[4*c+1], 14) ^ gmul(t[4*c+2], 11) ^ gmul(t[4*c+3], 13);
                    s[4*c+2] = gmul(t[4*c], 13) ^ gmul(t[4*c+1], 9) ^ gmul(t[4*c+2], 14) ^ gmul(t[4*c+3], 11);
                    s[4*c+3] = gmul(t[4*c], 11) ^ gmul(t[4*c+1], 13) ^ gmul(t[4*c+2], 9) ^ gmul(t[4*c+3], 14);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
        end
        for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
        return v;
    endfunction

    // drives start for one cycle, records the expected ciphertext, then scrambles the inputs
    task automatic start_op(input logic [127:0] k, input logic [127:0] p, input logic [127:0] expv);
        start = 1'b1;
        pt = p;
        key = k;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        pt = ~p;
        key = {k[63:0], k[127:64]};
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!done && n < 20) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        pt = '1;
        key = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b out=%h, want 0 0 0", busy, done, out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        int n, bc;
        logic [127:0] e;
        start_op(KB, PB, CB);
        @(negedge clk);
        checks++;
        if (dut.rk !== RKB) begin
            failures++;
            $display("FAIL b_round1_key: got %h want %h", dut.rk, RKB);
        end
        wait_done(n, bc);
        n++;
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL b_latency: got %0d cycles want 10", n);
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (out !== e) begin
            failures++;
            $display("FAIL b_ciphertext: got %h want %h", out, e);
        end
        @(negedge clk);
    endtask

    task automatic test_fips_c1();
        int n, bc;
        logic [127:0] e;
        start_op(KC, PC, CC);
        wait_done(n, bc);
        checks++;
        if (n != 10 || bc != 10) begin
            failures++;
            $display("FAIL c1_timing: latency %0d busy %0d cycles, want 10 and 10", n, bc);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL c1_done_busy: busy=%b done=%b, want 0 1", busy, done);
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (out !== e) begin
            failures++;
            $display("FAIL c1_ciphertext: got %h want %h", out, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out !== CC) begin
            failures++;
            $display("FAIL c1_pulse_hold: done=%b out=%h, want 0 %h", done, out, CC);
        end
    endtask

    task automatic test_back_to_back();
        int n, bc, bad;
        logic [127:0] e;
        start_op(KC, PC, CC);
        wait_done(n, bc);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (n != 10 || out !== e) begin
            failures++;
            $display("FAIL b2b_first: latency %0d out %h, want 10 %h", n, out, e);
        end
        start_op(KB, PB, CB);
        n = 0;
        bad = 0;
        while (!done && n < 20) begin
            if (out !== CC) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 10 || bad != 0) begin
            failures++;
            $display("FAIL b2b_second_timing: latency %0d, %0d cycles with out changed, want 10 0", n, bad);
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (out !== e) begin
            failures++;
            $display("FAIL b2b_second_ct: got %h want %h", out, e);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int n, nd;
        logic [127:0] e;
        start_op(KC, PC, CC);
        n = 0;
        while (!done && n < 20) begin
            start = (n == 3 || n == 7);
            pt = ~PC;
            key = ~KC;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (n != 10 || out !== e) begin
            failures++;
            $display("FAIL ignored_start_ct: latency %0d out %h, want 10 %h", n, out, e);
        end
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL ignored_start_extra: %0d cycles of done/busy after completion, want 0", nd);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, bc, nd;
        logic [127:0] e;
        start_op(KC, PC, CC);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL midreset_state: busy=%b done=%b out=%h, want 0 0 0", busy, done, out);
        end
        rst = 1'b0;
        exp_q.delete();
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            failures++;
            $display("FAIL midreset_no_done: %0d done pulses, want 0", nd);
        end
        start_op(KB, PB, CB);
        wait_done(n, bc);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        checks++;
        if (n != 10 || out !== e) begin
            failures++;
            $display("FAIL midreset_restart: latency %0d out %h, want 10 %h", n, out, e);
        end
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        int n, bc;
        logic [127:0] k, p, e, d;
        for (int i = 0; i < 100; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_op(k, p, model_enc(k, p));
            wait_done(n, bc);
            e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
            checks++;
            if (n != 10 || out !== e) begin
                failures++;
                $display("FAIL rand_ct[%0d]: latency %0d out %h, want 10 %h", i, n, out, e);
            end
            d = model_dec(k, out);
            checks++;
            if (d !== p) begin
                failures++;
                $display("FAIL rand_roundtrip[%0d]: recovered %h want %h", i, d, p);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_run();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
